rf_hazard_ctrl: RTL and testbench

Scoreboard-based hazard and stall controller for the stage-2 (register-file read) boundary of the pipelined processor. Tracks in-flight register writes between stage-2 issue and stage-4 writeback, stalls IR2 while a source operand is pending, injects NOP bubbles into IR3, and sequences the STOP drain-and-halt. Sits beside the stage-2 RF load control; its `Stall`/`Bubble` outputs gate PC/IR1/IR2 loads and IR3 input selection.

---
 rtl/rf_hazard_ctrl_pkg.sv | 65 ++++++
 rtl/rf_hazard_ctrl_if.sv | 25 ++
 rtl/rf_hazard_ctrl_sb_counter.sv | 36 +++
 rtl/rf_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_rf_hazard_ctrl.sv | 130 +++++++++++++
 5 files changed

// File: rtl/rf_hazard_ctrl_pkg.sv
// Shared decode helpers, constants and FSM state type for the stage-2 hazard controller.
package rf_hazard_ctrl_pkg;

  localparam int unsigned NumRegs = 4;
  localparam int unsigned CntW    = 2;

  localparam logic [3:0] OpLoad  = 4'b0000;
  localparam logic [3:0] OpStop  = 4'b0001;
  localparam logic [3:0] OpStore = 4'b0010;
  localparam logic [3:0] OpAdd   = 4'b0100;
  localparam logic [3:0] OpBz    = 4'b0101;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpNand  = 4'b1000;
  localparam logic [3:0] OpBnz   = 4'b1001;
  localparam logic [3:0] OpBpz   = 4'b1101;
  localparam logic [3:0] OpNop   = 4'b1111;
  localparam logic [2:0] OriMatch   = 3'b111;
  localparam logic [2:0] ShiftMatch = 3'b011;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  function automatic logic is_ori(logic [3:0] op);
    is_ori = (op != OpNop) && (op[2:0] == OriMatch);
  endfunction

  function automatic logic writes_dst(logic [3:0] op);
    writes_dst = 1'b0;
    if (op == OpNop || op == OpStop) begin
      writes_dst = 1'b0;
    end else if (is_ori(op)) begin
      writes_dst = 1'b1;
    end else begin
      case (op)
        OpLoad, OpAdd, OpSub, OpNand: writes_dst = 1'b1;
        default:                      writes_dst = (op[2:0] == ShiftMatch);
      endcase
    end
  endfunction

  // ORI always targets R1 regardless of the Rx field.
  function automatic logic [1:0] dst_reg(logic [7:0] ir);
    dst_reg = is_ori(ir[3:0]) ? 2'd1 : ir[7:6];
  endfunction

  function automatic logic [NumRegs-1:0] src_mask(logic [7:0] ir);
    logic [3:0] op;
    op       = ir[3:0];
    src_mask = '0;
    if (op == OpNop || op == OpStop) begin
      src_mask = '0;
    end else if (is_ori(op)) begin
      src_mask[1] = 1'b1;
    end else begin
      case (op)
        OpAdd, OpSub, OpNand, OpStore: begin
          src_mask[ir[7:6]] = 1'b1;
          src_mask[ir[5:4]] = 1'b1;
        end
        OpLoad:  src_mask[ir[5:4]] = 1'b1;
        default: if (op[2:0] == ShiftMatch) src_mask[ir[7:6]] = 1'b1;
      endcase
    end
  endfunction

endpackage

// File: rtl/rf_hazard_ctrl_if.sv
// Stage-2 instruction / writeback inputs and hazard-control outputs.
interface rf_hazard_ctrl_if;
  import rf_hazard_ctrl_pkg::*;

  logic [7:0]         IR2wire;
  logic               IR2Valid;
  logic               Flush;
  logic               WBEn;
  logic [1:0]         WBReg;
  logic               Stall;
  logic               Bubble;
  logic               Halted;
  logic [NumRegs-1:0] Pending;
  logic               SbErr;

  modport master (
    output IR2wire, IR2Valid, Flush, WBEn, WBReg,
    input  Stall, Bubble, Halted, Pending, SbErr
  );

  modport slave (
    input  IR2wire, IR2Valid, Flush, WBEn, WBReg,
    output Stall, Bubble, Halted, Pending, SbErr
  );
endinterface

// File: rtl/rf_hazard_ctrl_sb_counter.sv
// Per-register in-flight write counter: saturating up/down with underflow flag.
module rf_hazard_ctrl_sb_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic [Width-1:0] cnt_d_o,
  output logic             underflow_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel, so the count is left alone.
  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q != '1) cnt_d = cnt_q + Width'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) underflow_o = 1'b1;
      else             cnt_d       = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;

endmodule

// File: rtl/rf_hazard_ctrl.sv
// Scoreboard hazard/stall controller at the register-read stage, with STOP drain-and-halt.
module rf_hazard_ctrl
  import rf_hazard_ctrl_pkg::*;
(
  input logic             clock,
  input logic             reset,
  rf_hazard_ctrl_if.slave bus
);

  state_e state_q, state_d;

  logic [CntW-1:0]    cnt     [NumRegs];
  logic [CntW-1:0]    cnt_nxt [NumRegs];
  logic [NumRegs-1:0] inc, dec, uflow, pending, zero_nxt, src;
  logic [1:0]         dst;
  logic               wr, hazard, stall, bubble, issue, sb_err_q;

  assign src = src_mask(bus.IR2wire);
  assign dst = dst_reg(bus.IR2wire);
  assign wr  = writes_dst(bus.IR2wire[3:0]);

  // A count of one being written back this cycle is visible through the RF bypass.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned r = 0; r < NumRegs; r++) begin
      if (src[r] && cnt[r] != '0 &&
          !(cnt[r] == CntW'(1) && bus.WBEn && bus.WBReg == 2'(r))) begin
        hazard = 1'b1;
      end
    end
    if (wr && cnt[dst] == '1) hazard = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      StRun: begin
        stall  = bus.IR2Valid && !bus.Flush && hazard;
        bubble = stall || bus.Flush;
        issue  = bus.IR2Valid && !bus.Flush && !stall;
        if (issue && bus.IR2wire[3:0] == OpStop) state_d = StDrain;
      end
      StDrain: begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (&zero_nxt) state_d = StHalted;
      end
      StHalted: begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
      default: state_d = StRun;
    endcase
    if (reset) begin
      stall  = 1'b0;
      bubble = 1'b0;
    end
  end

  always_comb begin
    inc      = '0;
    dec      = '0;
    pending  = '0;
    zero_nxt = '0;
    for (int unsigned r = 0; r < NumRegs; r++) begin
      inc[r]      = issue && wr && (dst == 2'(r));
      dec[r]      = bus.WBEn && (bus.WBReg == 2'(r));
      pending[r]  = (cnt[r] != '0);
      zero_nxt[r] = (cnt_nxt[r] == '0);
    end
  end

  for (genvar r = 0; r < NumRegs; r++) begin : g_cnt
    rf_hazard_ctrl_sb_counter #(
      .Width(CntW)
    ) u_cnt (
      .clk_i      (clock),
      .rst_i      (reset),
      .inc_i      (inc[r]),
      .dec_i      (dec[r]),
      .cnt_o      (cnt[r]),
      .cnt_d_o    (cnt_nxt[r]),
      .underflow_o(uflow[r])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StRun;
      sb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sb_err_q <= sb_err_q | (|uflow);
    end
  end

  assign bus.Stall   = stall;
  assign bus.Bubble  = bubble;
  assign bus.Halted  = (state_q == StHalted) && !reset;
  assign bus.Pending = pending;
  assign bus.SbErr   = sb_err_q;

endmodule

// File: tb/tb_rf_hazard_ctrl.sv
// Directed scoreboard bench for rf_hazard_ctrl: per-cycle expectations queued, then checked.
module tb_rf_hazard_ctrl;

  typedef struct {
    string      tag;
    logic       stall;
    logic       bubble;
    logic       halted;
    logic [3:0] pend;
    logic       sberr;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  rf_hazard_ctrl_if bus ();

  rf_hazard_ctrl u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mk(logic [3:0] op, logic [1:0] rx, logic [1:0] ry);
    mk = {rx, ry, op};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle on the falling edge, queue its expectation, compare just before the rise.
  task automatic cyc(input logic rst, input logic [7:0] ir, input logic vld, input logic fl,
                     input logic wben, input logic [1:0] wbreg, input logic e_stall,
                     input logic e_bubble, input logic e_halted, input logic [3:0] e_pend,
                     input logic e_sberr, input string tag);
    exp_t e;
    @(negedge clock);
    reset        = rst;
    bus.IR2wire  = ir;
    bus.IR2Valid = vld;
    bus.Flush    = fl;
    bus.WBEn     = wben;
    bus.WBReg    = wbreg;
    e.tag = tag; e.stall = e_stall; e.bubble = e_bubble; e.halted = e_halted;
    e.pend = e_pend; e.sberr = e_sberr;
    sb_q.push_back(e);
    #4;
    e = sb_q.pop_front();
    check_eq({e.tag, ".stall"},  {7'd0, bus.Stall},  {7'd0, e.stall});
    check_eq({e.tag, ".bubble"}, {7'd0, bus.Bubble}, {7'd0, e.bubble});
    check_eq({e.tag, ".halted"}, {7'd0, bus.Halted}, {7'd0, e.halted});
    check_eq({e.tag, ".pend"},   {4'd0, bus.Pending}, {4'd0, e.pend});
    check_eq({e.tag, ".sberr"},  {7'd0, bus.SbErr},  {7'd0, e.sberr});
  endtask

  localparam logic [3:0] Load = 4'b0000, Stop = 4'b0001, Shift = 4'b0011, Add = 4'b0100;
  localparam logic [3:0] Sub = 4'b0110, Ori = 4'b0111, Nand = 4'b1000, Nop = 4'b1111;

  initial begin
    bus.IR2wire = mk(Nop, 0, 0); bus.IR2Valid = 0; bus.Flush = 0; bus.WBEn = 0; bus.WBReg = 0;
    @(negedge clock);
    // reset: outputs forced low even with Flush asserted
    cyc(1, mk(Add, 0, 0), 1, 1, 0, 0, 0, 0, 0, 4'b0000, 0, "rst");
    // ADD R2,R3 then dependent ADD R0,R2
    cyc(0, mk(Add, 2, 3), 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, "raw_issue");
    cyc(0, mk(Add, 0, 2), 1, 0, 0, 0, 1, 1, 0, 4'b0100, 0, "raw_stall");
    cyc(0, mk(Add, 0, 2), 1, 0, 1, 2, 0, 0, 0, 4'b0100, 0, "raw_bypass");
    cyc(0, mk(Nop, 0, 0), 1, 0, 0, 0, 0, 0, 0, 4'b0001, 0, "raw_after");
    cyc(0, mk(Nop, 0, 0), 0, 0, 1, 0, 0, 0, 0, 4'b0001, 0, "raw_wb0");
    // ORI then LOAD reading R1
    cyc(0, mk(Ori, 3, 3), 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, "ori_issue");
    cyc(0, mk(Load, 3, 1), 1, 0, 0, 0, 1, 1, 0, 4'b0010, 0, "ori_stall1");
    cyc(0, mk(Load, 3, 1), 1, 0, 0, 0, 1, 1, 0, 4'b0010, 0, "ori_stall2");
    cyc(0, mk(Load, 3, 1), 1, 0, 1, 1, 0, 0, 0, 4'b0010, 0, "ori_wb");
    cyc(0, mk(Nop, 0, 0), 0, 0, 1, 3, 0, 0, 0, 4'b1000, 0, "ld_wb3");
    cyc(0, mk(Nop, 0, 0), 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, "ori_clear");
    // Flush squashes a hazardous instruction without counting it
    cyc(0, mk(Shift, 2, 0), 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, "shf_issue");
    cyc(0, mk(Sub, 2, 0), 1, 1, 0, 0, 0, 1, 0, 4'b0100, 0, "flush");
    cyc(0, mk(Sub, 2, 0), 1, 0, 0, 0, 1, 1, 0, 4'b0100, 0, "post_flush");
    cyc(0, mk(Sub, 2, 0), 1, 0, 1, 2, 0, 0, 0, 4'b0100, 0, "sub_bypass");
    cyc(0, mk(Nop, 0, 0), 0, 0, 1, 2, 0, 0, 0, 4'b0100, 0, "sub_wb");
    cyc(0, mk(Nop, 0, 0), 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, "sub_clear");
    // Structural: three writes to R3 in flight block a fourth
    cyc(0, mk(Load, 3, 0), 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, "st_w1");
    cyc(0, mk(Load, 3, 0), 1, 0, 0, 0, 0, 0, 0, 4'b1000, 0, "st_w2");
    cyc(0, mk(Load, 3, 0), 1, 0, 0, 0, 0, 0, 0, 4'b1000, 0, "st_w3");
    cyc(0, mk(Load, 3, 0), 1, 0, 0, 0, 1, 1, 0, 4'b1000, 0, "st_full");
    cyc(0, mk(Load, 3, 0), 1, 0, 1, 3, 1, 1, 0, 4'b1000, 0, "st_full_wb");
    cyc(0, mk(Load, 3, 0), 1, 0, 0, 0, 0, 0, 0, 4'b1000, 0, "st_w4");
    cyc(0, mk(Nop, 0, 0), 0, 0, 1, 3, 0, 0, 0, 4'b1000, 0, "st_wb_a");
    cyc(0, mk(Nop, 0, 0), 0, 0, 1, 3, 0, 0, 0, 4'b1000, 0, "st_wb_b");
    cyc(0, mk(Nop, 0, 0), 0, 0, 1, 3, 0, 0, 0, 4'b1000, 0, "st_wb_c");
    cyc(0, mk(Nop, 0, 0), 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, "st_clear");
    // Spurious writeback sets sticky SbErr
    cyc(0, mk(Nop, 0, 0), 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0, "uflow");
    cyc(0, mk(Nop, 0, 0), 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, "sberr_set");
    cyc(0, mk(Nop, 0, 0), 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, "sberr_sticky");
    // STOP with two writes pending drains then halts
    cyc(0, mk(Add, 1, 2), 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, "stop_w1");
    cyc(0, mk(Nand, 0, 3), 1, 0, 0, 0, 0, 0, 0, 4'b0010, 1, "stop_w2");
    cyc(0, mk(Stop, 0, 0), 1, 0, 0, 0, 0, 0, 0, 4'b0011, 1, "stop_issue");
    cyc(0, mk(Add, 1, 1), 1, 1, 0, 0, 1, 1, 0, 4'b0011, 1, "drain");
    cyc(0, mk(Add, 1, 1), 1, 0, 1, 1, 1, 1, 0, 4'b0011, 1, "drain_wb1");
    cyc(0, mk(Add, 1, 1), 1, 0, 1, 0, 1, 1, 0, 4'b0001, 1, "drain_wb0");
    cyc(0, mk(Nop, 0, 0), 0, 0, 0, 0, 1, 1, 1, 4'b0000, 1, "halted");
    cyc(0, mk(Add, 0, 0), 1, 0, 0, 0, 1, 1, 1, 4'b0000, 1, "halted_hold");
    cyc(1, mk(Nop, 0, 0), 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, "halt_rst");
    cyc(0, mk(Nop, 0, 0), 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, "post_rst");
    // Reset in the middle of a stall empties the scoreboard
    cyc(0, mk(Add, 0, 1), 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, "run_issue");
    cyc(0, mk(Add, 2, 0), 1, 0, 0, 0, 1, 1, 0, 4'b0001, 0, "mid_stall");
    cyc(1, mk(Add, 2, 0), 1, 0, 0, 0, 0, 0, 0, 4'b0001, 0, "stall_rst");
    cyc(0, mk(Add, 2, 0), 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, "after_rst");
    cyc(0, mk(Nop, 0, 0), 0, 0, 0, 0, 0, 0, 0, 4'b0100, 0, "after_issue");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
